// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared state type and default widths for the serial sequence path
package seq_pkg;

   // Transmitter / detector state encoding
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2,
      ST_DONE  = 2'd3
   } seq_state_t;

   localparam int DEF_PAT_WIDTH = 4;
   localparam int DEF_CNT_WIDTH = 4;
   localparam int DEF_GAP_WIDTH = 4;

endpackage

// File: rtl/seq_pattern_tx_counter.sv
// rtl/seq_pattern_tx_counter.sv - up-counter with clear, enable and rollover flag
module tx_flex_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             clear,
   input  logic             count_enable,
   input  logic [WIDTH-1:0] rollover_val,
   output logic             rollover_flag
);

   logic [WIDTH-1:0] r_count;

   // Count up while enabled, wrapping to zero after reaching rollover_val; clear wins
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else if (count_enable) begin
         if (r_count == rollover_val) begin
            r_count <= '0;
         end else begin
            r_count <= r_count + {{(WIDTH-1){1'b0}}, 1'b1};
         end
      end
   end

   // Flag marks the cycle in which the count sits on its final value
   always_comb begin
      rollover_flag = (r_count == rollover_val);
   end

endmodule

// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - bit-serial repeating pattern transmitter with gap insertion
module seq_pattern_tx
   import seq_pkg::*;
#(
   parameter int PAT_WIDTH = DEF_PAT_WIDTH,
   parameter int CNT_WIDTH = DEF_CNT_WIDTH,
   parameter int GAP_WIDTH = DEF_GAP_WIDTH
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic [PAT_WIDTH-1:0] pattern,
   input  logic [CNT_WIDTH-1:0] repeat_cnt,
   input  logic [GAP_WIDTH-1:0] gap_len,
   output logic                 serial_out,
   output logic                 busy,
   output logic                 done
);

   localparam int BIT_W = (PAT_WIDTH > 2) ? $clog2(PAT_WIDTH) : 1;
   localparam logic [BIT_W-1:0]     C_BIT_LAST = BIT_W'(PAT_WIDTH - 1);
   localparam logic [CNT_WIDTH-1:0] C_REP_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [GAP_WIDTH-1:0] C_GAP_ONE  = {{(GAP_WIDTH-1){1'b0}}, 1'b1};

   seq_state_t           r_state;
   // Holds the bits still to be sent after the one currently on serial_out
   logic [PAT_WIDTH-2:0] r_shift;
   logic [PAT_WIDTH-1:0] r_pat;
   logic [CNT_WIDTH-1:0] r_rep_lat;
   logic [GAP_WIDTH-1:0] r_gap_lat;
   logic                 r_serial;
   logic                 r_busy;
   logic                 r_done;

   logic w_bit_clr, w_bit_en, w_bit_last;
   logic w_rep_clr, w_rep_en, w_rep_last;
   logic w_gap_clr, w_gap_en, w_gap_last;

   // Counter controls derived from the current state
   always_comb begin
      w_bit_clr = (r_state != ST_SHIFT) || abort;
      w_bit_en  = (r_state == ST_SHIFT);
      w_rep_clr = ((r_state != ST_SHIFT) && (r_state != ST_GAP)) || abort;
      w_rep_en  = (r_state == ST_SHIFT) && w_bit_last;
      w_gap_clr = (r_state != ST_GAP) || abort;
      w_gap_en  = (r_state == ST_GAP);
   end

   tx_flex_counter #(.WIDTH(BIT_W)) u_bit_cnt (
      .clk           (clk),
      .n_rst         (n_rst),
      .clear         (w_bit_clr),
      .count_enable  (w_bit_en),
      .rollover_val  (C_BIT_LAST),
      .rollover_flag (w_bit_last)
   );

   tx_flex_counter #(.WIDTH(CNT_WIDTH)) u_rep_cnt (
      .clk           (clk),
      .n_rst         (n_rst),
      .clear         (w_rep_clr),
      .count_enable  (w_rep_en),
      .rollover_val  (r_rep_lat - C_REP_ONE),
      .rollover_flag (w_rep_last)
   );

   tx_flex_counter #(.WIDTH(GAP_WIDTH)) u_gap_cnt (
      .clk           (clk),
      .n_rst         (n_rst),
      .clear         (w_gap_clr),
      .count_enable  (w_gap_en),
      .rollover_val  (r_gap_lat - C_GAP_ONE),
      .rollover_flag (w_gap_last)
   );

   // Transmit FSM: serial_out always carries the current MSB, outputs are registered
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state   <= ST_IDLE;
         r_shift   <= '0;
         r_pat     <= '0;
         r_rep_lat <= '0;
         r_gap_lat <= '0;
         r_serial  <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_serial <= 1'b0;
               r_busy   <= 1'b0;
               r_done   <= 1'b0;
               if (start) begin
                  r_pat     <= pattern;
                  r_rep_lat <= repeat_cnt;
                  r_gap_lat <= gap_len;
                  if (repeat_cnt != '0) begin
                     r_state  <= ST_SHIFT;
                     r_shift  <= pattern[PAT_WIDTH-2:0];
                     r_serial <= pattern[PAT_WIDTH-1];
                     r_busy   <= 1'b1;
                  end else begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end
               end
            end
            ST_SHIFT: begin
               if (abort) begin
                  r_state  <= ST_IDLE;
                  r_serial <= 1'b0;
                  r_busy   <= 1'b0;
               end else if (!w_bit_last) begin
                  r_serial <= r_shift[PAT_WIDTH-2];
                  r_shift  <= r_shift << 1;
               end else if (!w_rep_last) begin
                  if (r_gap_lat != '0) begin
                     r_state  <= ST_GAP;
                     r_serial <= 1'b0;
                  end else begin
                     r_shift  <= r_pat[PAT_WIDTH-2:0];
                     r_serial <= r_pat[PAT_WIDTH-1];
                  end
               end else begin
                  r_state  <= ST_DONE;
                  r_serial <= 1'b0;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
               end
            end
            ST_GAP: begin
               if (abort) begin
                  r_state  <= ST_IDLE;
                  r_serial <= 1'b0;
                  r_busy   <= 1'b0;
               end else if (w_gap_last) begin
                  r_state  <= ST_SHIFT;
                  r_shift  <= r_pat[PAT_WIDTH-2:0];
                  r_serial <= r_pat[PAT_WIDTH-1];
               end else begin
                  r_serial <= 1'b0;
               end
            end
            ST_DONE: begin
               r_state  <= ST_IDLE;
               r_serial <= 1'b0;
               r_busy   <= 1'b0;
               r_done   <= 1'b0;
            end
            default: begin
               r_state  <= ST_IDLE;
               r_serial <= 1'b0;
               r_busy   <= 1'b0;
               r_done   <= 1'b0;
            end
         endcase
      end
   end

   assign serial_out = r_serial;
   assign busy       = r_busy;
   assign done       = r_done;

endmodule
